// File: rtl/red_pitaya_adc_deser.sv
// red_pitaya_adc_deser
//   Rebuilds two 14-bit ADC channels from the 7-bit DDR bus after IDDR capture.
//   A training FSM picks the rising/falling bit pairing (same cycle or falling
//   half delayed by one cycle) against an alternating test pattern. The
//   assembled offset-binary word is converted to two's complement.
//   Single clock domain (ADC clock).
//
// Ports
//   clk_i      ADC clock
//   rstn_i     async active-low reset
//   dat_r_i    per channel, rising-edge bits {14,12,..,2} of the 16-bit word
//   dat_f_i    per channel, falling-edge bits {15,13,..,3} of the 16-bit word
//   train_i    pulse: (re)start alignment
//   bypass_i   skip training: slip=0, lock=1
//   adc_dat_o  per channel signed sample, 2 clk after dat_*_i
//   adc_vld_o  sample valid (lock delayed to match the pipeline)
//   lock_o     alignment locked
//   fail_o     both alignments exhausted without lock
//   slip_o     selected alignment (1 = falling half taken from previous cycle)
//   err_cnt_o  saturating pattern-mismatch count while locked
module red_pitaya_adc_deser #(
   parameter int unsigned   DW     = 14,
   parameter logic [DW-1:0] PAT_A  = 14'h2AAA,
   parameter logic [DW-1:0] PAT_B  = 14'h1555,
   parameter int unsigned   NMATCH = 64,
   parameter int unsigned   TMO    = 1024
)(
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [1:0][DW/2-1:0] dat_r_i,
   input  logic [1:0][DW/2-1:0] dat_f_i,
   input  logic                 train_i,
   input  logic                 bypass_i,
   output logic [1:0][DW-1:0]   adc_dat_o,
   output logic                 adc_vld_o,
   output logic                 lock_o,
   output logic                 fail_o,
   output logic                 slip_o,
   output logic [15:0]          err_cnt_o
);

   localparam int unsigned HW = DW / 2;
   localparam int unsigned CW = $clog2(NMATCH + 1);
   localparam int unsigned TW = $clog2(TMO);

   typedef enum logic [1:0] {IDLE, TRAIN, LOCKED, FAIL} state_t;

   state_t               state, state_n;
   logic                 slip, slip_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [TW-1:0]        tmo, tmo_n;
   logic [2:0]           flush, flush_n;
   logic                 phase, phase_n;
   logic                 exp_b, exp_b_n;
   logic [15:0]          err_cnt, err_n;
   logic                 byp;

   logic [1:0][HW-1:0]   r1, f1, fd, fsel;
   logic [1:0][DW-1:0]   raw, sample;
   logic                 v1;
   logic                 is_a, is_b, hit;

   // The slip register (fd) sits ahead of the common stage, so both
   // alignments see the same 2-clk latency from the input pins.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r1        <= '0;
         f1        <= '0;
         fd        <= '0;
         v1        <= 1'b0;
         adc_dat_o <= '0;
         adc_vld_o <= 1'b0;
      end else begin
         r1        <= dat_r_i;
         f1        <= dat_f_i;
         fd        <= f1;
         v1        <= lock_o;
         adc_vld_o <= v1;
         adc_dat_o <= v1 ? sample : '0;
      end
   end

   assign fsel = slip ? fd : f1;

   always_comb begin
      raw    = '0;
      sample = '0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
         for (int unsigned k = 0; k < HW; k++) begin
            raw[ch][2*k]   = r1[ch][k];
            raw[ch][2*k+1] = fsel[ch][k];
         end
         sample[ch] = {raw[ch][DW-1], ~raw[ch][DW-2:0]};
      end
   end

   assign is_a = (raw[0] == PAT_A) && (raw[1] == PAT_A);
   assign is_b = (raw[0] == PAT_B) && (raw[1] == PAT_B);
   // Before the phase is known either pattern word counts and sets the phase.
   assign hit  = phase ? (exp_b ? is_b : is_a) : (is_a | is_b);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state   <= IDLE;
         slip    <= 1'b0;
         cnt     <= '0;
         tmo     <= '0;
         flush   <= '0;
         phase   <= 1'b0;
         exp_b   <= 1'b0;
         err_cnt <= '0;
         byp     <= 1'b0;
      end else begin
         state   <= state_n;
         slip    <= slip_n;
         cnt     <= cnt_n;
         tmo     <= tmo_n;
         flush   <= flush_n;
         phase   <= phase_n;
         exp_b   <= exp_b_n;
         err_cnt <= err_n;
         byp     <= bypass_i;
      end
   end

   always_comb begin
      state_n = state;
      slip_n  = slip;
      cnt_n   = cnt;
      tmo_n   = tmo;
      flush_n = flush;
      phase_n = phase;
      exp_b_n = exp_b;
      err_n   = err_cnt;
      if (bypass_i) begin
         state_n = IDLE;
         slip_n  = 1'b0;
         cnt_n   = '0;
         tmo_n   = '0;
         flush_n = '0;
         phase_n = 1'b0;
      end else if (train_i) begin
         state_n = TRAIN;
         slip_n  = 1'b0;
         cnt_n   = '0;
         tmo_n   = '0;
         flush_n = '0;
         phase_n = 1'b0;
         err_n   = '0;
      end else begin
         case (state)
            TRAIN: begin
               tmo_n = tmo + 1'b1;
               if (flush != '0) begin
                  flush_n = flush - 1'b1;
               end else if (hit) begin
                  cnt_n   = cnt + 1'b1;
                  phase_n = 1'b1;
                  exp_b_n = phase ? ~exp_b : is_a;
                  if (cnt == CW'(NMATCH - 1)) state_n = LOCKED;
               end else begin
                  cnt_n   = '0;
                  phase_n = 1'b0;
               end
               // Lock takes priority over a timeout in the same cycle.
               if (state_n == TRAIN && tmo == TW'(TMO - 1)) begin
                  if (!slip) begin
                     slip_n  = 1'b1;
                     cnt_n   = '0;
                     tmo_n   = '0;
                     flush_n = 3'd4;
                     phase_n = 1'b0;
                  end else begin
                     state_n = FAIL;
                  end
               end
            end
            LOCKED: begin
               exp_b_n = ~exp_b;
               if (!hit && err_cnt != '1) err_n = err_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign lock_o    = (state == LOCKED) | byp;
   assign fail_o    = (state == FAIL);
   assign slip_o    = slip;
   assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_red_pitaya_adc_deser.sv
module tb_red_pitaya_adc_deser;

   localparam int unsigned NMATCH = 64;
   localparam int unsigned TMO    = 1024;
   localparam logic [13:0] PAT_A  = 14'h2AAA;
   localparam logic [13:0] PAT_B  = 14'h1555;

   logic              clk = 1'b0;
   logic              rstn;
   logic [1:0][6:0]   dat_r, dat_f;
   logic              train, bypass;
   logic [1:0][13:0]  adc_dat;
   logic              adc_vld, lock, fail, slip;
   logic [15:0]       err_cnt;

   int                n_chk = 0;
   int                n_fail = 0;

   logic [1:0][6:0]   hr[$];
   logic [1:0][6:0]   hf[$];
   logic [1:0][6:0]   fprev = '0;
   bit                ph = 1'b0;

   always #5 clk = ~clk;

   red_pitaya_adc_deser #(
      .DW(14), .PAT_A(PAT_A), .PAT_B(PAT_B), .NMATCH(NMATCH), .TMO(TMO)
   ) dut (
      .clk_i(clk), .rstn_i(rstn), .dat_r_i(dat_r), .dat_f_i(dat_f),
      .train_i(train), .bypass_i(bypass), .adc_dat_o(adc_dat),
      .adc_vld_o(adc_vld), .lock_o(lock), .fail_o(fail), .slip_o(slip),
      .err_cnt_o(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Apply one cycle of pin data, record it, sample 1 time unit after the edge.
   task automatic step(input logic [1:0][6:0] r, input logic [1:0][6:0] f);
      dat_r = r;
      dat_f = f;
      hr.push_back(r);
      hf.push_back(f);
      @(posedge clk);
      #1;
   endtask

   task automatic step_rand();
      logic [1:0][6:0] r, f;
      r = {7'($urandom), 7'($urandom)};
      f = {7'($urandom), 7'($urandom)};
      step(r, f);
   endtask

   // Split 16-bit ADC words into pin bits; skew delays the falling half by a cycle.
   task automatic send(input logic [15:0] w0, input logic [15:0] w1, input bit skew);
      logic [1:0][6:0] r, f, fo;
      for (int k = 0; k < 7; k++) begin
         r[0][k] = w0[2*k+2];
         f[0][k] = w0[2*k+3];
         r[1][k] = w1[2*k+2];
         f[1][k] = w1[2*k+3];
      end
      fo    = skew ? fprev : f;
      fprev = f;
      step(r, fo);
   endtask

   function automatic logic [15:0] pat(input bit b);
      return b ? {PAT_B, 2'b00} : {PAT_A, 2'b00};
   endfunction

   task automatic send_pat(input bit skew);
      logic [15:0] w;
      w  = pat(ph);
      ph = ~ph;
      send(w, w, skew);
   endtask

   // Reference: rebuild the 16-bit word from recorded pins, take w[15:2],
   // keep the MSB and invert the remaining 13 bits.
   function automatic logic [13:0] exp_smp(input int j, input int ch, input bit slp);
      logic [6:0]  r, f;
      logic [15:0] w;
      logic [13:0] raw;
      r = hr[j][ch];
      f = slp ? hf[j-1][ch] : hf[j][ch];
      w = '0;
      for (int k = 0; k < 7; k++) begin
         w[2*k+2] = r[k];
         w[2*k+3] = f[k];
      end
      raw = w[15:2];
      return {raw[13], 13'h1FFF - raw[12:0]};
   endfunction

   // Output visible now belongs to the input applied two edges ago.
   task automatic check_data(input string tag, input bit slp);
      int j;
      j = hr.size() - 2;
      chk({tag, "_ch0"}, 32'(adc_dat[0]), 32'(exp_smp(j, 0, slp)));
      chk({tag, "_ch1"}, 32'(adc_dat[1]), 32'(exp_smp(j, 1, slp)));
      chk({tag, "_vld"}, 32'(adc_vld), 32'd1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] w;

      // Reset with live data on the pins
      rstn = 1'b0; train = 1'b0; bypass = 1'b0; dat_r = '0; dat_f = '0;
      repeat (6) step_rand();
      chk("rst_dat0", 32'(adc_dat[0]), 32'd0);
      chk("rst_dat1", 32'(adc_dat[1]), 32'd0);
      chk("rst_vld",  32'(adc_vld), 32'd0);
      chk("rst_lock", 32'(lock), 32'd0);
      chk("rst_fail", 32'(fail), 32'd0);
      chk("rst_slip", 32'(slip), 32'd0);
      chk("rst_err",  32'(err_cnt), 32'd0);
      rstn = 1'b1;
      repeat (3) step_rand();
      chk("idle_vld",  32'(adc_vld), 32'd0);
      chk("idle_lock", 32'(lock), 32'd0);
      chk("idle_dat0", 32'(adc_dat[0]), 32'd0);

      // Aligned training, then ramp
      repeat (2) send_pat(1'b0);
      train = 1'b1; send_pat(1'b0); train = 1'b0;
      n = 0;
      while (lock !== 1'b1 && n < int'(NMATCH + 4)) begin send_pat(1'b0); n++; end
      chk("t2_lock", 32'(lock), 32'd1);
      chk("t2_slip", 32'(slip), 32'd0);
      chk("t2_fail", 32'(fail), 32'd0);
      chk("t2_err",  32'(err_cnt), 32'd0);
      repeat (2) send_pat(1'b0);
      for (int i = 0; i < 48; i++) begin
         send({14'(i), 2'b00}, {14'(i * 37 + 5), 2'b00}, 1'b0);
         check_data("t2_ramp", 1'b0);
         if (i == 1) chk("t2_zero", 32'(adc_dat[0]), 32'h1FFF);
      end

      // Skewed bus: falling half arrives one cycle late
      train = 1'b1; send_pat(1'b1); train = 1'b0;
      n = 0;
      while (lock !== 1'b1 && n < int'(TMO + NMATCH + 8)) begin send_pat(1'b1); n++; end
      chk("t3_lock", 32'(lock), 32'd1);
      chk("t3_slip", 32'(slip), 32'd1);
      chk("t3_err",  32'(err_cnt), 32'd0);
      chk("t3_not_early", 32'(n > int'(TMO)), 32'd1);
      repeat (2) send_pat(1'b1);
      repeat (24) begin
         step_rand();
         check_data("t3_rand", 1'b1);
      end

      // Garbage during training exhausts both alignments
      train = 1'b1; step_rand(); train = 1'b0;
      n = 0;
      while (fail !== 1'b1 && n < int'(2 * TMO + 8)) begin
         step_rand();
         n++;
         if (n == int'(2 * TMO - 4)) chk("t4_early", 32'(fail), 32'd0);
      end
      chk("t4_fail", 32'(fail), 32'd1);
      chk("t4_lock", 32'(lock), 32'd0);
      chk("t4_slip", 32'(slip), 32'd1);
      train = 1'b1; send_pat(1'b0); train = 1'b0;
      chk("t4_clr_fail", 32'(fail), 32'd0);
      chk("t4_clr_slip", 32'(slip), 32'd0);
      chk("t4_clr_lock", 32'(lock), 32'd0);
      chk("t4_clr_err",  32'(err_cnt), 32'd0);

      // Locked error counting and saturation
      n = 0;
      while (lock !== 1'b1 && n < int'(NMATCH + 4)) begin send_pat(1'b0); n++; end
      chk("t5_lock", 32'(lock), 32'd1);
      repeat (2) send_pat(1'b0);
      chk("t5_err0", 32'(err_cnt), 32'd0);
      for (int i = 0; i < 12; i++) begin
         w  = pat(ph);
         ph = ~ph;
         if (i == 2 || i == 5) send(16'h0000, 16'h0000, 1'b0);
         else if (i == 8)      send(w, w ^ 16'h0004, 1'b0);
         else                  send(w, w, 1'b0);
      end
      repeat (3) send_pat(1'b0);
      chk("t5_err3",  32'(err_cnt), 32'd3);
      chk("t5_lock3", 32'(lock), 32'd1);
      // N zero words: the last one is still in flight, so N-1 are counted.
      repeat (1000) send(16'h0000, 16'h0000, 1'b0);
      chk("t5_err_mid", 32'(err_cnt), 32'd1002);
      repeat (69000) send(16'h0000, 16'h0000, 1'b0);
      chk("t5_err_sat",  32'(err_cnt), 32'hFFFF);
      chk("t5_lock_sat", 32'(lock), 32'd1);
      bypass = 1'b1;
      repeat (5) step_rand();
      chk("t5_byp_err",  32'(err_cnt), 32'hFFFF);
      chk("t5_byp_lock", 32'(lock), 32'd1);
      bypass = 1'b0;
      step_rand();
      chk("t5_unbyp_lock", 32'(lock), 32'd0);
      chk("t5_unbyp_fail", 32'(fail), 32'd0);

      // Async reset mid-training, then bypass
      train = 1'b1; step_rand(); train = 1'b0;
      repeat (10) step_rand();
      #2 rstn = 1'b0;
      #1;
      chk("t6_rst_lock", 32'(lock), 32'd0);
      chk("t6_rst_fail", 32'(fail), 32'd0);
      chk("t6_rst_slip", 32'(slip), 32'd0);
      chk("t6_rst_err",  32'(err_cnt), 32'd0);
      chk("t6_rst_vld",  32'(adc_vld), 32'd0);
      chk("t6_rst_dat",  32'(adc_dat[0]), 32'd0);
      repeat (2) step_rand();
      rstn = 1'b1;
      bypass = 1'b1; train = 1'b1; step_rand(); train = 1'b0;
      chk("t6_byp_lock", 32'(lock), 32'd1);
      chk("t6_byp_fail", 32'(fail), 32'd0);
      chk("t6_byp_slip", 32'(slip), 32'd0);
      for (int i = 0; i < 40; i++) begin
         send({14'(i * 3), 2'b00}, {~14'(i * 3), 2'b00}, 1'b0);
         if (i >= 1) check_data("t6_byp", 1'b0);
      end
      #2 rstn = 1'b0;
      #1;
      chk("t6_rst2_lock", 32'(lock), 32'd0);
      chk("t6_rst2_vld",  32'(adc_vld), 32'd0);
      chk("t6_rst2_dat0", 32'(adc_dat[0]), 32'd0);
      chk("t6_rst2_dat1", 32'(adc_dat[1]), 32'd0);
      step_rand();
      rstn = 1'b1;
      step_rand();
      chk("t6_rel_lock", 32'(lock), 32'd1);
      bypass = 1'b0;
      step_rand();
      chk("t6_end_lock", 32'(lock), 32'd0);
      chk("t6_end_fail", 32'(fail), 32'd0);
      chk("t6_end_slip", 32'(slip), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
